mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage's data accesses.
- Serialises each 32-bit access into four byte cycles and returns the assembled word.
- Drives fetching_data, which the MEM stage uses to raise its stall request while a data access is pending.

Parameters:
ADDR_W, 32, width of the RAM byte address.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset
if_req  in  1  IF read request; held high until if_done or withdrawn on flush
if_addr  in  32  IF word address (bits [1:0] ignored)
if_rdata  out  32  fetched instruction word, lane k = byte at base+k
if_done  out  1  one-cycle completion pulse for IF
mem_req  in  1  MEM-stage request (load or store); held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  32  data address (bits [1:0] ignored for sequencing)
mem_sel  in  4  byte-lane enables for stores; ignored for loads
mem_wdata  in  32  store data, lane-replicated by the MEM stage
mem_rdata  out  32  loaded word, all four lanes
mem_done  out  1  one-cycle completion pulse for MEM
fetching_data  out  1  mem_req & ~mem_done (combinational)
ram_a  out  ADDR_W  RAM byte address
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte; valid the cycle after ram_a is presented
ram_wr  out  1  RAM write strobe

Behaviour:
- Reset: rst is synchronous, active-high.
  - Registered outputs after reset: state IDLE, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0.
  - Combinational outputs with state IDLE: ram_a=0, ram_dout=0, ram_wr=0.
  - Asserting rst mid-transaction abandons it; no done pulse is issued and ram_wr is low from the next cycle.
- States: IDLE, READ, WRITE, DONE. Register owner records IF or MEM. The 3-bit cnt register counts cycles within READ/WRITE.
- Base address: base = {addr[ADDR_W-1:2],2'b00}, latched at grant.
- Grant in IDLE when any request is high:
  - mem_req has fixed priority over if_req.
  - The grant edge latches owner, base, we, sel and wdata, and sets cnt=0.
  - Next state: WRITE if the owner is MEM with mem_we=1; otherwise READ.
- READ, for cnt 0..4, one cycle each:
  - cnt<=3: ram_a=base+cnt, ram_wr=0.
  - cnt>=1: capture ram_din into lane cnt-1 of the owner's rdata register.
  - At cnt=4, go to DONE.
  - For a grant at cycle G, DONE is cycle G+6.
- WRITE, for cnt 0..3, one cycle each:
  - ram_a=base+cnt, ram_dout=wdata[8cnt+7:8cnt], ram_wr=sel[cnt].
  - After cnt=3, go to DONE. DONE is cycle G+5.
  - sel=0000 still takes 4 cycles with no strobes.
- DONE:
  - Owner's done pulse is high for exactly this cycle, with rdata valid.
  - rdata holds until the owner's next read capture.
  - Next state IDLE.
  - The requester must drop or replace its request in the cycle after done; a request seen in IDLE is always treated as new.
- IF flush: if owner=IF and if_req is low in any READ cycle, go to IDLE at the next edge with no if_done. Partial if_rdata is not guaranteed.
- MEM requests are never withdrawn; writes are never aborted.
- Earliest back-to-back grant is the IDLE cycle after DONE, so minimum spacing is 7 cycles for reads.
- fetching_data is high from the cycle mem_req rises until the mem_done cycle, inclusive of waits behind an IF transaction.
- if_done and mem_done are never high in the same cycle.

Optional Feature:
- Macro ARB_FAIR_EN defined:
  - Round-robin arbitration: when both requests are high in IDLE, grant the requester not granted last.
  - A last_owner register, reset to IF, means MEM wins the first tie.
- Undefined: MEM has fixed priority, and IF may starve under continuous MEM traffic.

Test Plan:
- IF read, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103:
  - if_done in cycle G+6 with if_rdata=0x00100513.
  - ram_a sequence is 0x100..0x103.
- MEM store, mem_addr=0x202, mem_sel=1100, mem_wdata=0xBEEFBEEF:
  - ram_wr high only at ram_a=0x202 (ram_dout=0xEF) and 0x203 (ram_dout=0xBE).
  - mem_done in cycle G+5; fetching_data high throughout.
- Simultaneous if_req and mem_req in IDLE, feature off:
  - MEM is served first; IF is granted in the IDLE cycle after mem_done.
  - With ARB_FAIR_EN and last owner MEM, IF is served first.
- IF read at 0x40 with if_req dropped during READ cnt=2:
  - No if_done; IDLE next cycle.
  - A pending mem_req is granted in that IDLE cycle.
- Store with mem_sel=0000: no ram_wr pulses; mem_done in cycle G+5.
- rst asserted during WRITE cnt=1 with mem_sel=1111:
  - ram_wr=0 from next cycle; no mem_done.
  - All outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, mem_port_arbiter and the byte-wide RAM.
// The arbiter takes the slave modport; requesters and RAM sit on the master side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              fetching_data;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_din,
    output if_rdata, if_done, mem_rdata, mem_done, fetching_data, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_din,
    input  if_rdata, if_done, mem_rdata, mem_done, fetching_data, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between IF and MEM, serialising each word into four byte cycles.
// Define ARB_FAIR_EN for round-robin arbitration on simultaneous requests (default: MEM priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t            r_state, w_next;
  owner_t            r_owner, w_grant;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:2] r_base;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata, r_mem_rdata;
  logic              r_if_done, r_mem_done;
  logic              w_req_any;
  logic              w_capture;
  logic [1:0]        w_lane;
  logic              w_unused_addr_lsbs;

  assign w_req_any          = bus.if_req | bus.mem_req;
  assign w_unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

`ifdef ARB_FAIR_EN
  owner_t r_last_owner;

  // On a tie the requester that did not win the previous grant goes first.
  always_comb begin
    w_grant = OWN_IF;
    if (bus.mem_req && bus.if_req)
      w_grant = (r_last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
    else if (bus.mem_req)
      w_grant = OWN_MEM;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last_owner <= OWN_IF;
    else if (r_state == S_IDLE && w_req_any)
      r_last_owner <= w_grant;
  end
`else
  always_comb begin
    w_grant = bus.mem_req ? OWN_MEM : OWN_IF;
  end
`endif

  // Read data lags the address by one cycle, so cnt 1..4 captures lanes 0..3.
  assign w_capture = (r_state == S_READ) && (r_cnt != 3'd0);
  assign w_lane    = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_next       = r_state;
    bus.ram_a    = '0;
    bus.ram_dout = '0;
    bus.ram_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any)
          w_next = (w_grant == OWN_MEM && bus.mem_we) ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (r_cnt <= 3'd3)
          bus.ram_a = {r_base, r_cnt[1:0]};
        if (r_owner == OWN_IF && !bus.if_req)
          w_next = S_IDLE;
        else if (r_cnt == 3'd4)
          w_next = S_DONE;
      end
      S_WRITE: begin
        bus.ram_a    = {r_base, r_cnt[1:0]};
        bus.ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        bus.ram_wr   = r_sel[r_cnt[1:0]];
        if (r_cnt == 3'd3)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_base      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Done is registered on entry to DONE so it is high exactly for that cycle.
      r_if_done  <= (w_next == S_DONE) && (r_owner == OWN_IF);
      r_mem_done <= (w_next == S_DONE) && (r_owner == OWN_MEM);
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_grant;
            r_cnt   <= '0;
            r_base  <= (w_grant == OWN_MEM) ? bus.mem_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
            r_sel   <= bus.mem_sel;
            r_wdata <= bus.mem_wdata;
          end
        end
        S_READ, S_WRITE: r_cnt <= r_cnt + 3'd1;
        default: ;
      endcase
      if (w_capture) begin
        if (r_owner == OWN_IF)
          r_if_rdata[{w_lane, 3'b000} +: 8] <= bus.ram_din;
        else
          r_mem_rdata[{w_lane, 3'b000} +: 8] <= bus.ram_din;
      end
    end
  end

  assign bus.if_rdata      = r_if_rdata;
  assign bus.mem_rdata     = r_mem_rdata;
  assign bus.if_done       = r_if_done;
  assign bus.mem_done      = r_mem_done;
  assign bus.fetching_data = bus.mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a completion scoreboard and a RAM-write scoreboard
// are filled as requests are driven and drained on done pulses / write strobes.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[11:0]];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_done(input bit is_mem, input bit chk, input logic [31:0] d, input int unsigned at);
    exp_t e;
    e.is_mem   = is_mem;
    e.chk_data = chk;
    e.data     = d;
    e.cyc      = at;
    sb.push_back(e);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  // One cycle: sample at the falling edge, retire scoreboard entries, drop finished requests.
  task automatic step();
    exp_t e;
    wr_t  w;
    @(negedge clk);
    if (bus.if_done || bus.mem_done) begin
      check("done_exclusive", 32'(bus.if_done & bus.mem_done), 32'd0);
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_owner", 32'(bus.mem_done), 32'(e.is_mem));
        check("done_cycle", cyc, e.cyc);
        if (e.chk_data) check("rdata", e.is_mem ? bus.mem_rdata : bus.if_rdata, e.data);
      end
      if (bus.if_done)  bus.if_req  = 1'b0;
      if (bus.mem_done) bus.mem_req = 1'b0;
    end
    if (bus.ram_wr) begin
      check("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("wr_addr", bus.ram_a, w.a);
        check("wr_data", 32'(bus.ram_dout), 32'(w.d));
      end
    end
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (sb.size() != 0 || wq.size() != 0); i++) step();
    check("drain_done", 32'(sb.size()), 32'd0);
    check("drain_wr", 32'(wq.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_sel   = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
    ram[12'h200] <= 8'h78; ram[12'h201] <= 8'h56; ram[12'h202] <= 8'h34; ram[12'h203] <= 8'h12;
    ram[12'h204] <= 8'hA1; ram[12'h205] <= 8'hB2; ram[12'h206] <= 8'hC3; ram[12'h207] <= 8'hD4;

    repeat (3) @(negedge clk);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_mem_done", 32'(bus.mem_done), 32'd0);
    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    rst = 1'b0;
    step();

    // IF read of 0x100: four byte addresses, done at G+6.
    c = cyc;
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    expect_done(1'b0, 1'b1, 32'h00100513, c + 6);
    for (int k = 0; k < 4; k++) begin
      step();
      check("if_ram_a", bus.ram_a, 32'h100 + 32'(k));
      check("if_ram_wr", 32'(bus.ram_wr), 32'd0);
    end
    drain(10);

    // Store to upper two lanes of word 0x200, done at G+5.
    c = cyc;
    bus.mem_addr  = 32'h202;
    bus.mem_we    = 1'b1;
    bus.mem_sel   = 4'b1100;
    bus.mem_wdata = 32'hBEEFBEEF;
    bus.mem_req   = 1'b1;
    expect_wr(32'h202, 8'hEF);
    expect_wr(32'h203, 8'hBE);
    expect_done(1'b1, 1'b0, 32'h0, c + 5);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("st_fetching", 32'(bus.fetching_data), 32'd1);
    end
    drain(10);

    // Simultaneous requests; the MEM load sees the bytes written above.
    c = cyc;
    bus.if_addr  = 32'h100;
    bus.if_req   = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h200;
    bus.mem_req  = 1'b1;
`ifdef ARB_FAIR_EN
    expect_done(1'b0, 1'b1, 32'h00100513, c + 6);
    expect_done(1'b1, 1'b1, 32'hBEEF5678, c + 13);
`else
    expect_done(1'b1, 1'b1, 32'hBEEF5678, c + 6);
    expect_done(1'b0, 1'b1, 32'h00100513, c + 13);
`endif
    step();
    check("tie_fetching", 32'(bus.fetching_data), 32'd1);
    drain(20);

    // IF flush at READ cnt=2 with a MEM load waiting; load granted in the following IDLE.
    c = cyc;
    bus.if_addr = 32'h40;
    bus.if_req  = 1'b1;
    step();
    step();
    step();
    bus.if_req   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h206;
    bus.mem_req  = 1'b1;
    expect_done(1'b1, 1'b1, 32'hD4C3B2A1, c + 10);
    step();
    check("flush_idle_ram_a", bus.ram_a, 32'h0);
    drain(20);

    // Store with no lanes enabled: no strobes, same latency.
    c = cyc;
    bus.mem_addr  = 32'h300;
    bus.mem_we    = 1'b1;
    bus.mem_sel   = 4'b0000;
    bus.mem_wdata = 32'hFFFFFFFF;
    bus.mem_req   = 1'b1;
    expect_done(1'b1, 1'b0, 32'h0, c + 5);
    drain(10);

    // Reset during WRITE cnt=1: only the first two strobes, then everything at reset values.
    bus.mem_addr  = 32'h310;
    bus.mem_we    = 1'b1;
    bus.mem_sel   = 4'b1111;
    bus.mem_wdata = 32'h44332211;
    bus.mem_req   = 1'b1;
    expect_wr(32'h310, 8'h11);
    expect_wr(32'h311, 8'h22);
    step();
    step();
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    step();
    check("rrst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rrst_ram_a", bus.ram_a, 32'h0);
    check("rrst_ram_dout", 32'(bus.ram_dout), 32'd0);
    check("rrst_mem_done", 32'(bus.mem_done), 32'd0);
    check("rrst_if_done", 32'(bus.if_done), 32'd0);
    check("rrst_if_rdata", bus.if_rdata, 32'h0);
    check("rrst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rrst_fetching", 32'(bus.fetching_data), 32'd0);
    rst = 1'b0;
    drain(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
